// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - ID-to-EX hazard, vector serialisation and branch-shadow sequencer
//
// Purpose:
//   Sits between decode and execute of the vector ASIP. Tracks every
//   in-flight register write in a PIPE_DEPTH-deep scoreboard (slot 0 = EX),
//   stalls the instruction in ID on a read-after-write hazard, holds EX for
//   the full length of a multi-cycle vector ALU op, and kills the branch
//   shadow after any PC-writing instruction.
//
// Parameters:
//   PIPE_DEPTH     stages after ID holding an uncommitted write (2..4)
//   VEC_CYCLES     cycles a vector ALU op occupies EX (1..8)
//   BRANCH_SHADOW  flush cycles after a PC-writing op issues (1..3)
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   id_valid                      ID holds a valid instruction
//   id_src_a/b, id_src_a/b_used   source register indices and read flags
//   id_dst, id_reg_we             destination register and write enable
//   id_is_vec                     multi-cycle vector ALU op
//   id_is_load                    result comes from memory
//   id_pc_write                   nonzero = PC-writing instruction
//   stall_if, stall_id            hold PC / IF-ID register and the ID instruction
//   flush_id                      invalidate the ID instruction
//   issue                         ID instruction advances into EX this cycle
//   stall_cycles                  saturating count of cycles with stall_id = 1
//
// Build option:
//   PIPE_FWD_EN  when defined, EX/MEM results are bypassed and only a
//                load-use on slot 0 is a hazard; otherwise any valid
//                writing slot blocks a matching source.

module pipe_hazard_ctrl #(
  parameter int PIPE_DEPTH    = 3,
  parameter int VEC_CYCLES    = 4,
  parameter int BRANCH_SHADOW = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [3:0]  id_src_a,
  input  logic [3:0]  id_src_b,
  input  logic        id_src_a_used,
  input  logic        id_src_b_used,
  input  logic [3:0]  id_dst,
  input  logic        id_reg_we,
  input  logic        id_is_vec,
  input  logic        id_is_load,
  input  logic [2:0]  id_pc_write,
  output logic        stall_if,
  output logic        stall_id,
  output logic        flush_id,
  output logic        issue,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    VEC_BUSY = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  // vec_cnt counts the remaining busy cycles after the issue cycle itself.
  localparam logic [3:0] VEC_LOAD    = 4'(VEC_CYCLES - 1);
  localparam logic [1:0] SHADOW_LOAD = 2'(BRANCH_SHADOW);
  localparam logic       VEC_MULTI   = (VEC_CYCLES > 1);

  state_t state;
  state_t state_next;

  logic [3:0] vec_cnt;
  logic [1:0] shadow_cnt;

  // Scoreboard, one bit/field per slot; index 0 is EX, PIPE_DEPTH-1 is WB.
  logic [PIPE_DEPTH-1:0]      slot_valid;
  logic [PIPE_DEPTH-1:0]      slot_we;
  logic [PIPE_DEPTH-1:0]      slot_load;
  logic [PIPE_DEPTH-1:0][3:0] slot_dst;

  logic src_a_hit;
  logic src_b_hit;
  logic hazard;
  logic is_pc_write;
  logic enter_flush;
  logic enter_vec;

  assign is_pc_write = |id_pc_write;

  // A PC-writing op that is also tagged vector is treated only as PC-writing.
  assign enter_flush = issue & is_pc_write;
  assign enter_vec   = issue & id_is_vec & ~is_pc_write & VEC_MULTI;

  // ------------------------------------------------------------------
  // Hazard detection against the scoreboard
  // ------------------------------------------------------------------
  always_comb begin
    src_a_hit = 1'b0;
    src_b_hit = 1'b0;
`ifdef PIPE_FWD_EN
    // Only a load still in EX cannot be bypassed: its data arrives from MEM.
    if (slot_valid[0] && slot_we[0] && slot_load[0]) begin
      src_a_hit = id_src_a_used && (id_src_a == slot_dst[0]);
      src_b_hit = id_src_b_used && (id_src_b == slot_dst[0]);
    end
`else
    // No bypass: the consumer waits until the producer has retired past WB.
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (slot_valid[i] && slot_we[i]) begin
        if (id_src_a_used && (id_src_a == slot_dst[i])) src_a_hit = 1'b1;
        if (id_src_b_used && (id_src_b == slot_dst[i])) src_b_hit = 1'b1;
      end
    end
`endif
    hazard = id_valid && (src_a_hit || src_b_hit);
  end

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (enter_flush) begin
          state_next = FLUSH;
        end else if (enter_vec) begin
          state_next = VEC_BUSY;
        end
      end
      VEC_BUSY: begin
        if (vec_cnt <= 4'd1) state_next = RUN;
      end
      FLUSH: begin
        if (shadow_cnt <= 2'd1) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs. Everything is held at 0 while reset is asserted, even
  // though the ID inputs may already carry a valid instruction.
  // ------------------------------------------------------------------
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    issue    = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (hazard) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
          end else if (id_valid) begin
            issue = 1'b1;
          end
        end
        VEC_BUSY: begin
          stall_if = 1'b1;
          stall_id = 1'b1;
        end
        FLUSH: begin
          // Shadow kill dominates: any hazard in ID is irrelevant now.
          flush_id = 1'b1;
        end
        default: begin
          stall_if = 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Vector-busy and branch-shadow counters
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt    <= 4'd0;
      shadow_cnt <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (enter_flush) shadow_cnt <= SHADOW_LOAD;
          if (enter_vec)   vec_cnt    <= VEC_LOAD;
        end
        VEC_BUSY: vec_cnt    <= vec_cnt - 4'd1;
        FLUSH:    shadow_cnt <= shadow_cnt - 2'd1;
        default: begin
          vec_cnt    <= 4'd0;
          shadow_cnt <= 2'd0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Scoreboard shift
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      slot_we    <= '0;
      slot_load  <= '0;
      slot_dst   <= '0;
    end else begin
      for (int i = PIPE_DEPTH - 1; i >= 1; i--) begin
        if ((state == VEC_BUSY) && (i == 1)) begin
          // The vector op stays parked in EX, so MEM sees bubbles.
          slot_valid[i] <= 1'b0;
          slot_we[i]    <= 1'b0;
          slot_load[i]  <= 1'b0;
          slot_dst[i]   <= 4'd0;
        end else begin
          slot_valid[i] <= slot_valid[i-1];
          slot_we[i]    <= slot_we[i-1];
          slot_load[i]  <= slot_load[i-1];
          slot_dst[i]   <= slot_dst[i-1];
        end
      end

      if (state == VEC_BUSY) begin
        slot_valid[0] <= slot_valid[0];
      end else if (issue) begin
        slot_valid[0] <= 1'b1;
        slot_we[0]    <= id_reg_we;
        slot_load[0]  <= id_is_load;
        slot_dst[0]   <= id_dst;
      end else begin
        slot_valid[0] <= 1'b0;
        slot_we[0]    <= 1'b0;
        slot_load[0]  <= 1'b0;
        slot_dst[0]   <= 4'd0;
      end
    end
  end

  // The WB slot's fields only retire; fold them so they have a reader.
  logic unused_retire;
  assign unused_retire = ^{slot_valid, slot_we, slot_load, slot_dst};

  // ------------------------------------------------------------------
  // Saturating stall counter
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 16'd0;
    end else if (stall_id && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int D = 3;
  localparam int V = 4;
  localparam int B = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  id_src_a;
  logic [3:0]  id_src_b;
  logic        id_src_a_used;
  logic        id_src_b_used;
  logic [3:0]  id_dst;
  logic        id_reg_we;
  logic        id_is_vec;
  logic        id_is_load;
  logic [2:0]  id_pc_write;
  logic        stall_if;
  logic        stall_id;
  logic        flush_id;
  logic        issue;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .PIPE_DEPTH   (D),
    .VEC_CYCLES   (V),
    .BRANCH_SHADOW(B)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_src_a     (id_src_a),
    .id_src_b     (id_src_b),
    .id_src_a_used(id_src_a_used),
    .id_src_b_used(id_src_b_used),
    .id_dst       (id_dst),
    .id_reg_we    (id_reg_we),
    .id_is_vec    (id_is_vec),
    .id_is_load   (id_is_load),
    .id_pc_write  (id_pc_write),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .flush_id     (flush_id),
    .issue        (issue),
    .stall_cycles (stall_cycles)
  );

  typedef struct packed {
    logic       valid;
    logic [3:0] sa;
    logic       ua;
    logic [3:0] sb;
    logic       ub;
    logic [3:0] dst;
    logic       we;
    logic       vec;
    logic       load;
    logic [2:0] pcw;
  } instr_t;

  int vectors     = 0;
  int miscompares = 0;

  logic [19:0] exp_q[$];
  logic [19:0] got_bus;
  assign got_bus = {stall_if, stall_id, flush_id, issue, stall_cycles};

  // Reference model: each register remembers the last cycle in which a
  // reader of it must still wait; the sequencer remembers until which cycle
  // it is flushing or serialising a vector op.
  int cyc = 0;
  int busy_until[16];
  int load_until[16];
  int flush_until;
  int vec_until;
  int stall_cnt;
  logic last_issue;
  logic last_flush;

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      busy_until[r] = -1;
      load_until[r] = -1;
    end
    flush_until = -1;
    vec_until   = -1;
    stall_cnt   = 0;
    last_issue  = 1'b0;
    last_flush  = 1'b0;
  endtask

  function automatic logic reg_busy(input logic [3:0] r);
`ifdef PIPE_FWD_EN
    return load_until[r] >= cyc;
`else
    return busy_until[r] >= cyc;
`endif
  endfunction

  task automatic record_issue(input instr_t in);
    int ex_last;
    ex_last = cyc + 1;
    if (in.pcw != 3'd0) begin
      flush_until = cyc + B;
    end else if (in.vec && (V > 1)) begin
      vec_until = cyc + V - 1;
      ex_last   = cyc + V;
    end
    if (in.we) begin
      if (ex_last + D - 1 > busy_until[in.dst]) busy_until[in.dst] = ex_last + D - 1;
      if (in.load && (ex_last > load_until[in.dst])) load_until[in.dst] = ex_last;
    end
  endtask

  task automatic model_cycle(input instr_t in, output logic [19:0] e);
    logic e_if, e_id, e_fl, e_is;
    e_if = 1'b0; e_id = 1'b0; e_fl = 1'b0; e_is = 1'b0;
    if (!rst_n) begin
      model_reset();
      e = 20'h0;
    end else begin
      if (cyc <= flush_until) begin
        e_fl = 1'b1;
      end else if (cyc <= vec_until) begin
        e_if = 1'b1;
        e_id = 1'b1;
      end else if (in.valid) begin
        if ((in.ua && reg_busy(in.sa)) || (in.ub && reg_busy(in.sb))) begin
          e_if = 1'b1;
          e_id = 1'b1;
        end else begin
          e_is = 1'b1;
        end
      end
      e = {e_if, e_id, e_fl, e_is, 16'(stall_cnt)};
      if (e_id && (stall_cnt < 65535)) stall_cnt++;
      if (e_is) record_issue(in);
      last_issue = e_is;
      last_flush = e_fl;
    end
    cyc++;
  endtask

  function automatic instr_t mk(input logic v, input int sa, input logic ua,
                                input int sb, input logic ub, input int dst,
                                input logic we, input logic vec, input logic load,
                                input logic [2:0] pcw);
    instr_t r;
    r.valid = v;
    r.sa = 4'(sa); r.ua = ua;
    r.sb = 4'(sb); r.ub = ub;
    r.dst = 4'(dst); r.we = we;
    r.vec = vec; r.load = load; r.pcw = pcw;
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r.valid = ($urandom_range(0, 99) < 85);
    r.sa    = 4'($urandom_range(0, 5));
    r.ua    = ($urandom_range(0, 99) < 70);
    r.sb    = 4'($urandom_range(0, 5));
    r.ub    = ($urandom_range(0, 99) < 50);
    r.dst   = 4'($urandom_range(0, 5));
    r.we    = ($urandom_range(0, 99) < 80);
    r.vec   = ($urandom_range(0, 99) < 15);
    r.load  = ($urandom_range(0, 99) < 30);
    r.pcw   = ($urandom_range(0, 99) < 8) ? 3'($urandom_range(1, 7)) : 3'd0;
    return r;
  endfunction

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  task automatic step(input instr_t in);
    logic [19:0] e;
    @(posedge clk);
    #1;
    id_valid      = in.valid;
    id_src_a      = in.sa;
    id_src_a_used = in.ua;
    id_src_b      = in.sb;
    id_src_b_used = in.ub;
    id_dst        = in.dst;
    id_reg_we     = in.we;
    id_is_vec     = in.vec;
    id_is_load    = in.load;
    id_pc_write   = in.pcw;
    model_cycle(in, e);
    exp_q.push_back(e);
  endtask

  // Monitor: the outputs are meaningful every cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check("cycle_outputs", got_bus, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

  instr_t idle, cur, chain;

  initial begin
    idle  = mk(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3'd0);
    chain = mk(1'b1, 1, 1'b1, 0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 3'd0);
    rst_n = 1'b0;
    id_valid = 1'b0; id_src_a = '0; id_src_b = '0; id_src_a_used = 1'b0;
    id_src_b_used = 1'b0; id_dst = '0; id_reg_we = 1'b0; id_is_vec = 1'b0;
    id_is_load = 1'b0; id_pc_write = '0;
    model_reset();

    // Valid instruction in ID during reset: nothing may come out.
    step(mk(1'b1, 2, 1'b1, 3, 1'b1, 4, 1'b1, 1'b0, 1'b0, 3'd0));
    step(mk(1'b1, 2, 1'b1, 3, 1'b1, 4, 1'b1, 1'b0, 1'b0, 3'd0));
    @(negedge clk);
    #1 check("reset_outputs", got_bus, 20'h0);
    #1 rst_n = 1'b1;

    // ALU dst=5 then consumer of r5.
    step(mk(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 3'd0));
    repeat (4) step(mk(1'b1, 5, 1'b1, 0, 1'b0, 9, 1'b1, 1'b0, 1'b0, 3'd0));
    step(idle);
    @(negedge clk);
`ifdef PIPE_FWD_EN
    #1 check("raw_stall_count", {4'h0, stall_cycles}, 20'd0);
`else
    #1 check("raw_stall_count", {4'h0, stall_cycles}, 20'd3);
`endif

    // Load-use and ALU producer on r6 feeding src_b.
    step(mk(1'b1, 0, 1'b0, 0, 1'b0, 6, 1'b1, 1'b0, 1'b1, 3'd0));
    repeat (4) step(mk(1'b1, 0, 1'b0, 6, 1'b1, 12, 1'b1, 1'b0, 1'b0, 3'd0));
    step(idle);
    step(idle);
    step(mk(1'b1, 0, 1'b0, 0, 1'b0, 6, 1'b1, 1'b0, 1'b0, 3'd0));
    repeat (4) step(mk(1'b1, 0, 1'b0, 6, 1'b1, 12, 1'b1, 1'b0, 1'b0, 3'd0));

    // Jump followed by a consumer that has a hazard during the shadow.
    step(mk(1'b1, 0, 1'b0, 0, 1'b0, 8, 1'b1, 1'b0, 1'b0, 3'd0));
    step(mk(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3'b010));
    repeat (3) step(mk(1'b1, 8, 1'b1, 0, 1'b0, 13, 1'b1, 1'b0, 1'b0, 3'd0));

    // Vector op with an independent op waiting behind it.
    step(mk(1'b1, 0, 1'b0, 0, 1'b0, 10, 1'b1, 1'b1, 1'b0, 3'd0));
    repeat (5) step(mk(1'b1, 2, 1'b1, 0, 1'b0, 11, 1'b1, 1'b0, 1'b0, 3'd0));

    // Asynchronous reset in the second VEC_BUSY cycle.
    step(mk(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b1, 1'b0, 3'd0));
    step(mk(1'b1, 2, 1'b1, 0, 1'b0, 11, 1'b1, 1'b0, 1'b0, 3'd0));
    step(mk(1'b1, 2, 1'b1, 0, 1'b0, 11, 1'b1, 1'b0, 1'b0, 3'd0));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_drop", got_bus, 20'h0);
    step(mk(1'b1, 2, 1'b1, 0, 1'b0, 11, 1'b1, 1'b0, 1'b0, 3'd0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(mk(1'b1, 7, 1'b1, 7, 1'b1, 14, 1'b1, 1'b0, 1'b0, 3'd0));
    step(idle);

    // Random traffic; an instruction stays in ID until issued or flushed.
    cur = rand_instr();
    repeat (1500) begin
      step(cur);
      if (last_issue || last_flush || !cur.valid) cur = rand_instr();
    end

    // Self-dependent vector chain: stalls 6 of every 7 cycles.
    repeat (77000) step(chain);

    @(negedge clk);
    #1 check("stall_saturated", {4'h0, stall_cycles}, 20'h0FFFF);
    check("queue_drained", 20'(exp_q.size()), 20'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencer for the vectorial ASIP, placed between the decode stage and execute. It consumes the decoded control fields of the instruction in ID and keeps a scoreboard of in-flight register writes through EX/MEM/WB. From these it generates stall, flush and issue controls. It also serialises multi-cycle vector ALU operations and kills the branch shadow after any PC-writing instruction.

## Interface
- `PIPE_DEPTH`, 3: stages after ID that hold an uncommitted register write (EX, MEM, WB); legal values 2–4.
- `VEC_CYCLES`, 4: cycles a vector ALU op occupies EX; legal values 1–8.
- `BRANCH_SHADOW`, 1: cycles of flush after a PC-writing instruction issues; legal values 1–3.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a valid instruction.
- `id_src_a`, `id_src_b` in 4: source register indices.
- `id_src_a_used`, `id_src_b_used` in 1: the source is actually read.
- `id_dst` in 4: destination register (`RegToWrite`).
- `id_reg_we` in 1: `RegWriteEnSc | RegWriteEnVec`.
- `id_is_vec` in 1: vector ALU op; EX is occupied for `VEC_CYCLES` cycles.
- `id_is_load` in 1: the result comes from memory (`WriteRegFrom` = memory).
- `id_pc_write` in 3: `PcWriteEn`; any nonzero value is a PC-writing instruction.
- `stall_if` out 1: hold PC and the IF/ID register.
- `stall_id` out 1: hold the ID instruction.
- `flush_id` out 1: invalidate the ID instruction.
- `issue` out 1: the ID instruction advances into EX this cycle.
- `stall_cycles` out 16: saturating count of cycles with `stall_id` = 1.

## Operation
- Scoreboard: `PIPE_DEPTH` slots, each holding {valid, dst, we, is_load}. Slot 0 is EX.
- Each cycle the slots shift toward WB, and the last slot retires.
  - Slot 0 loads the ID fields when `issue` = 1; otherwise it loads a bubble (valid = 0).
- Hazard: `id_valid` = 1, a source is used, and its index matches the dst of a valid slot with we = 1. The hazard rule depends on `PIPE_FWD_EN` (see Configuration).
- FSM states: RUN, VEC_BUSY, FLUSH.
  - RUN:
    - If `id_valid` = 1 with no hazard: `issue` = 1.
    - If `id_valid` = 1 with a hazard: `stall_if` = `stall_id` = 1 and `issue` = 0.
    - After an issued op with `id_pc_write` ≠ 0: go to FLUSH and load `shadow_cnt` = `BRANCH_SHADOW`.
    - Otherwise, after an issued `id_is_vec` op with `VEC_CYCLES` > 1: go to VEC_BUSY and load `vec_cnt` = `VEC_CYCLES`−1.
  - VEC_BUSY:
    - Outputs: `stall_if` = `stall_id` = 1 and `issue` = 0.
    - Slot 0 holds its contents; slots 1 and up shift, and slot 1 receives a bubble.
    - `vec_cnt` decrements each cycle; on reaching 1 the FSM returns to RUN on the next edge.
  - FLUSH:
    - Outputs: `flush_id` = 1, `issue` = 0, `stall_*` = 0; slot 0 receives a bubble.
    - `shadow_cnt` decrements each cycle; at 1 the FSM returns to RUN.
- Priority: FLUSH > VEC_BUSY > hazard stall > issue.
- A PC-writing op that is also flagged vector is handled as PC-writing only.
- `id_valid` = 0 in RUN: no stall, `issue` = 0, bubble into slot 0.
- `stall_cycles` saturates at 16'hFFFF; it does not wrap.
- Reset (asynchronous, at any point including mid-VEC_BUSY or mid-FLUSH):
  - FSM goes to RUN, all slots are invalidated, counters are cleared.
  - While `rst_n` = 0, all control outputs are 0 and `stall_cycles` = 0.

## Timing
- All outputs are combinational from the FSM state, the scoreboard and the ID inputs. State updates on the rising edge of `clk`.
- Without forwarding: a producer issued at cycle t with its dependent at t+1 gives stalls at t+1..t+`PIPE_DEPTH` and issue at t+`PIPE_DEPTH`+1.
- With forwarding: a load issued at t with a dependent at t+1 gives 1 stall cycle and issue at t+2. ALU producers cause 0 stall cycles.
- A vector op issued at t gives stalls at t+1..t+`VEC_CYCLES`−1; the next issue is possible at t+`VEC_CYCLES`.
- A jump issued at t gives `flush_id` = 1 at t+1..t+`BRANCH_SHADOW`; the next issue is possible at t+`BRANCH_SHADOW`+1.

## Configuration
- `PIPE_FWD_EN` defined:
  - EX/MEM results are bypassed, so a hazard is only a source match on slot 0 with is_load = 1 (load-use).
- `PIPE_FWD_EN` undefined:
  - A hazard is a source match against any valid writing slot, so the consumer waits until the producer has retired past WB.

## Test plan
- Without forwarding, `PIPE_DEPTH`=3: ALU op writing dst=5 issued at t, then a consumer with src_a=5 -> `stall_id` high exactly at t+1..t+3, `issue` at t+4, `stall_cycles` = 3.
- With `PIPE_FWD_EN`: load dst=6, then a consumer with src_b=6 -> 1 stall cycle. ALU dst=6 then the same consumer -> 0 stall cycles.
- Vector op with `VEC_CYCLES`=4 issued at t with an independent op waiting -> stalls at t+1..t+3, `issue` at t+4, and the MEM slot carries 3 bubbles.
- Jump (`id_pc_write`=3'b010) issued at t with `BRANCH_SHADOW`=1 -> `flush_id`=1 and `issue`=0 at t+1, normal issue at t+2. A hazard present during the flush cycle is masked: no stall, no count increment.
- `rst_n` pulsed low asynchronously at cycle 2 of VEC_BUSY -> all outputs drop to 0 immediately. After release, a dependent op on the previous dst issues with no stall because the scoreboard is empty.
- Force a permanent hazard for 70000 cycles -> `stall_cycles` holds at 16'hFFFF.
